p2s_gearbox: RTL
================

# p2s_gearbox

Parametrised parallel-to-serial gearbox: accepts one DATA_W-bit word over a valid/ready handshake and emits it as DATA_W/LANE_W beats of LANE_W bits over a second valid/ready handshake, LSB-lane-first or MSB-lane-first. It marks the final beat of each word with `s_last_o`. It supports zero-bubble back-to-back words. It sits between a word-wide producer and a narrow serial link or lane interface.

## Interface
- `DATA_W`, default 16: parallel word width. Must be a multiple of `LANE_W`; elaboration `$error` otherwise.
- `LANE_W`, default 4: serial beat width. `LANE_W` = 1 gives a pure bit-serial block.
- `MSB_FIRST`, default 0: 0 sends the lane at bits [LANE_W-1:0] first; 1 sends the top lane first.
- Derived: `BEATS` = DATA_W/LANE_W; counter width = max(1, $clog2(BEATS)).
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p_valid_i`  in  1  parallel word valid.
- `p_data_i`  in  DATA_W  parallel word.
- `p_ready_o`  out  1  block can accept a word this cycle.
- `s_valid_o`  out  1  serial beat valid.
- `s_data_o`  out  LANE_W  serial beat data.
- `s_last_o`  out  1  current beat is the last of its word.
- `s_ready_i`  in  1  downstream accepts beat.

## Operation
- State machine has two states.
  - IDLE: no word held.
  - SHIFT: word held, beats pending.
- Registers:
  - `state`
  - `data_q` [DATA_W]
  - `beat_q` [counter width]
- Handshakes:
  - p-accept = `p_valid_i & p_ready_o`.
  - s-accept = `s_valid_o & s_ready_i`.
- `p_ready_o` = (state==IDLE) | (state==SHIFT & s_ready_i & beat_q==BEATS-1).
  - This is combinational from `s_ready_i` and enables back-to-back words.
- `s_valid_o` = (state==SHIFT).
- `s_last_o` = `s_valid_o` & (beat_q==BEATS-1).
- `s_data_o`:
  - MSB_FIRST=0: `data_q[LANE_W-1:0]`.
  - MSB_FIRST=1: `data_q[DATA_W-1 -: LANE_W]`.
  - Forced to 0 when `s_valid_o`=0.
- On p-accept: `data_q` <= `p_data_i`, `beat_q` <= 0, state <= SHIFT.
  - p-accept takes priority over the shift when it coincides with the last-beat s-accept.
- On s-accept of a non-last beat:
  - MSB_FIRST=0: `data_q` shifts right by LANE_W.
  - MSB_FIRST=1: `data_q` shifts left by LANE_W.
  - Vacated lane fills with 0; `beat_q` increments.
- On s-accept of the last beat with no p-accept: state <= IDLE, `beat_q` <= 0.
- Backpressure: while `s_valid_o` & ~`s_ready_i`, the values of `s_data_o`, `s_last_o` and `beat_q` hold unchanged.
- `p_valid_i` asserted in SHIFT before the last beat is not accepted (`p_ready_o`=0). The producer holds the word.
- BEATS==1: every beat is last, and the block degenerates to a one-entry register slice with full throughput.
- Reset values (the reset state is IDLE):
  - `state`=IDLE, `data_q`=0, `beat_q`=0.
  - Outputs: `p_ready_o`=1 (when `reset` is deasserted), `s_valid_o`=0, `s_data_o`=0, `s_last_o`=0.
- Reset mid-word: the held word is discarded. There are no partial beats after reset.

## Timing
- Latency: word accepted at edge N gives first beat valid in cycle N+1. The first beat is registered; there is no combinational path from `p_data_i` to `s_data_o`.
- With `s_ready_i` held high, a word occupies exactly BEATS cycles. Sustained throughput is one word per BEATS cycles with zero idle cycles between words.
- The last-beat s-accept and the next p-accept occur in the same cycle. The next word's first beat appears the following cycle.
- Each beat holds until s-accept; there is no timeout.
- Only combinational path: `s_ready_i` to `p_ready_o`.

## Test plan
- Reset, then an LSB-first word. Configuration: DATA_W=16, LANE_W=4, MSB_FIRST=0.
  - Stimulus: apply reset, then idle.
  - Required: `p_ready_o`=1, `s_valid_o`=0, `s_data_o`=0.
  - Stimulus: send 0xA5C3 with `s_ready_i`=1.
  - Required: beats 0x3, 0xC, 0x5, 0xA in 4 consecutive cycles starting 1 cycle after accept; `s_last_o` only on 0xA.
- MSB-first: same word with MSB_FIRST=1.
  - Required: beats 0xA, 0x5, 0xC, 0x3; `s_last_o` on 0x3.
- Backpressure:
  - Stimulus: drop `s_ready_i` for 3 cycles on beat 2 of 0x1234.
  - Required: `s_data_o`=0x3 stable for those 3 cycles; no beat lost or duplicated; `p_ready_o`=0 throughout.
- Back-to-back:
  - Stimulus: hold `p_valid_i`=1 with words 0x1111, 0x2222, 0x3333 and `s_ready_i`=1.
  - Required: 12 contiguous beats with no gap; `p_ready_o` pulses high on each last-beat cycle; `s_last_o` every 4th beat.
- Reset mid-word:
  - Stimulus: assert `reset` after beat 1 of 0xBEEF.
  - Required: next cycle `s_valid_o`=0, `p_ready_o`=1; a subsequent word 0x0F0F serialises cleanly as 0xF, 0x0, 0xF, 0x0.
- Edge configurations:
  - DATA_W=8, LANE_W=8: 0x5A passes as a single beat with `s_last_o`=1, at one word per cycle.
  - DATA_W=4, LANE_W=1: 0b1011 LSB-first gives 1, 1, 0, 1.

Source files
------------

// File: rtl/p2s_gearbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : p2s_gearbox
// Purpose  : Parallel-to-serial gearbox. Takes one DATA_W-bit word over a
//            valid/ready handshake and emits it as DATA_W/LANE_W beats of
//            LANE_W bits, LSB lane first or MSB lane first. The final beat
//            of each word is flagged with s_last_o. Back-to-back words run
//            with no idle cycle between them.
// Revision : 1.0 - initial release
// ============================================================================
module p2s_gearbox #(
  parameter int DATA_W    = 16,
  parameter int LANE_W    = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid_i,
  input  logic [DATA_W-1:0] p_data_i,
  output logic              p_ready_o,
  output logic              s_valid_o,
  output logic [LANE_W-1:0] s_data_o,
  output logic              s_last_o,
  input  logic              s_ready_i
);

  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Word width must split evenly into lanes.
  if ((DATA_W % LANE_W) != 0) begin : g_width_check
    $error("p2s_gearbox: DATA_W (%0d) must be a multiple of LANE_W (%0d)", DATA_W, LANE_W);
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  beat_q;

  logic              is_last;
  logic              p_accept;
  logic              s_accept;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] shifted;

  // Lane selection and shift direction are fixed at elaboration time.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign lane    = data_q[DATA_W-1 -: LANE_W];
    assign shifted = data_q << LANE_W;
  end else begin : g_lsb_first
    assign lane    = data_q[LANE_W-1:0];
    assign shifted = data_q >> LANE_W;
  end

  assign is_last   = (beat_q == LAST_BEAT);
  assign s_valid_o = (state == SHIFT);
  assign s_last_o  = s_valid_o & is_last;
  assign s_data_o  = s_valid_o ? lane : '0;

  // The only combinational path: accepting the last beat frees the holding
  // register in the same cycle, so the next word can be taken with no bubble.
  assign p_ready_o = (state == IDLE) | ((state == SHIFT) & s_ready_i & is_last);

  assign p_accept  = p_valid_i & p_ready_o;
  assign s_accept  = s_valid_o & s_ready_i;

  // Word load has priority over the final shift; otherwise each accepted
  // beat advances the lane, and the last one returns the block to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      beat_q <= '0;
    end else if (p_accept) begin
      state  <= SHIFT;
      data_q <= p_data_i;
      beat_q <= '0;
    end else if (s_accept) begin
      if (is_last) begin
        state  <= IDLE;
        beat_q <= '0;
      end else begin
        data_q <= shifted;
        beat_q <= beat_q + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
